// File: rtl/core_pkg.sv
// Shared core types and constants used by the front-end stages.
// Fetch FSM states, NOP encoding and default PC vectors.
package core_pkg;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_PC  = 32'h0000_0100;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, one outstanding imem request,
// in-order delivery to decode, predict-not-taken with EX redirects.
module fetch_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] TRAP_PC  = DEF_TRAP_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic        redirect_taken,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        flush,
    output logic        misalign
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_q, pend_d;
    logic         pend_v_q, pend_v_d;
    logic         kill_q, kill_d;
    logic         live_q;
    logic         ifv_d;
    logic [31:0]  ifpc_d, ifi_d;
    logic         redir;
    logic [31:0]  dst;

    function automatic logic [31:0] next_pc(
        input logic [31:0] pc,
        input logic [31:0] tgt,
        input logic        take
    );
        if (!take) begin
            return pc + 32'd4;
        end
        if (tgt[1:0] != 2'b00) begin
            return TRAP_PC;
        end
        return tgt;
    endfunction

    assign redir     = redirect_valid && redirect_taken;
    assign dst       = next_pc(pc_q, redirect_target, 1'b1);
    assign imem_req  = live_q && (state_q == REQ);
    assign imem_addr = {pc_q[31:2], 2'b00};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        kill_d   = kill_q;
        ifv_d    = if_valid;
        ifpc_d   = if_pc;
        ifi_d    = if_instr;
        unique case (state_q)
            REQ: begin
                if (redir) begin
                    if (!live_q) begin
                        pc_d = dst;
                    end else if (!imem_ready) begin
                        // request on the bus must stay put; park the target
                        kill_d   = 1'b1;
                        pend_v_d = 1'b1;
                        pend_d   = dst;
                    end else begin
                        pc_d     = dst;
                        kill_d   = 1'b1;
                        pend_v_d = 1'b0;
                        state_d  = WAIT;
                    end
                end else if (live_q && imem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d  = REQ;
                    kill_d   = 1'b0;
                    pend_v_d = 1'b0;
                    if (redir) begin
                        pc_d = dst;
                    end else if (kill_q) begin
                        if (pend_v_q) begin
                            pc_d = pend_q;
                        end
                    end else begin
                        ifv_d   = 1'b1;
                        ifpc_d  = pc_q;
                        ifi_d   = imem_rdata;
                        pc_d    = next_pc(pc_q, redirect_target, 1'b0);
                        state_d = HOLD;
                    end
                end else if (redir) begin
                    pc_d     = dst;
                    kill_d   = 1'b1;
                    pend_v_d = 1'b0;
                end
            end
            HOLD: begin
                if (redir) begin
                    ifv_d   = 1'b0;
                    pc_d    = dst;
                    state_d = REQ;
                end else if (!stall) begin
                    ifv_d   = 1'b0;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC;
            pend_q   <= RESET_PC;
            pend_v_q <= 1'b0;
            kill_q   <= 1'b0;
            live_q   <= 1'b0;
            if_valid <= 1'b0;
            if_pc    <= RESET_PC;
            if_instr <= NOP_INSTR;
            flush    <= 1'b0;
            misalign <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            kill_q   <= kill_d;
            live_q   <= 1'b1;
            if_valid <= ifv_d;
            if_pc    <= ifpc_d;
            if_instr <= ifi_d;
            flush    <= redir;
            misalign <= redir && (redirect_target[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus a randomized
// run scored against a next-expected-PC model and a memory model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic        redirect_taken = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    bit          m_out = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = 32'h0;
    int          m_dup = 0;
    int          lat = 1;
    bit          rnd_rdy = 1'b0;
    bit          rnd_lat = 1'b0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_taken  (redirect_taken),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .flush           (flush),
        .misalign        (misalign)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // one clock of the memory model; called and returns at negedge
    task automatic cycle();
        logic        acc;
        logic [31:0] a;
        imem_rvalid = m_out && (m_cnt == 0);
        imem_rdata  = imem_rvalid ? instr_of(m_addr) : 32'hDEAD_BEEF;
        imem_ready  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        acc = imem_req && imem_ready;
        a   = imem_addr;
        @(posedge clk);
        if (imem_rvalid) m_out = 1'b0;
        else if (m_out && m_cnt > 0) m_cnt--;
        if (acc && !rst) begin
            if (m_out) m_dup++;
            m_out  = 1'b1;
            m_cnt  = (rnd_lat ? int'($urandom_range(1, 3)) : lat) - 1;
            m_addr = a;
        end
        if (rst) m_out = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_taken = 1'b0;
        rnd_rdy = 1'b0;
        rnd_lat = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl req=%b valid=%b want 0 0", imem_req, if_valid);
        end
        checks++;
        if (flush !== 1'b0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulse flush=%b mis=%b want 0 0", flush, misalign);
        end
        checks++;
        if (if_pc !== 32'h0 || if_instr !== 32'h13) begin
            errors++;
            $display("FAIL reset_if pc=%h instr=%h want 0 13", if_pc, if_instr);
        end
        rst = 1'b0;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop req=%b want 0", imem_req);
        end
        cycle();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] e;
        lat = 1;
        for (int i = 0; i < 9; i++) begin
            e = 32'((i / 3) * 4);
            checks++;
            if (if_valid !== (i % 3 == 2)) begin
                errors++;
                $display("FAIL seq_valid c%0d got %b", i, if_valid);
            end
            checks++;
            if (imem_req !== (i % 3 == 0)) begin
                errors++;
                $display("FAIL seq_req c%0d got %b", i, imem_req);
            end
            if (i % 3 == 0) begin
                checks++;
                if (imem_addr !== e) begin
                    errors++;
                    $display("FAIL seq_addr got %h want %h", imem_addr, e);
                end
            end
            if (i % 3 == 2) begin
                checks++;
                if (if_pc !== e || if_instr !== instr_of(e)) begin
                    errors++;
                    $display("FAIL seq_if pc=%h instr=%h want %h %h",
                             if_pc, if_instr, e, instr_of(e));
                end
            end
            cycle();
        end
    endtask

    task automatic test_stall();
        int n;
        lat = 3;
        n = 0;
        while (!if_valid && n < 20) begin
            cycle();
            n++;
        end
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== instr_of(32'hC)) begin
            errors++;
            $display("FAIL stall_deliver v=%b pc=%h want 1 c", if_valid, if_pc);
        end
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'hC ||
                if_instr !== instr_of(32'hC) || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold c%0d v=%b pc=%h req=%b want 1 c 0",
                         i, if_valid, if_pc, imem_req);
            end
        end
        stall = 1'b0;
        cycle();
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL stall_release v=%b req=%b addr=%h want 0 1 10",
                     if_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect();
        int          n;
        int          extra;
        bit          got_addr;
        logic [31:0] first_addr;
        do_reset();
        lat = 2;
        n = 0;
        while (!(imem_req && imem_addr == 32'h8) && n < 40) begin
            cycle();
            n++;
        end
        cycle();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait req=%b want 0", imem_req);
        end
        redirect_valid  = 1'b1;
        redirect_taken  = 1'b1;
        redirect_target = 32'h200;
        cycle();
        redirect_valid = 1'b0;
        checks++;
        if (flush !== 1'b1 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush flush=%b mis=%b want 1 0", flush, misalign);
        end
        extra = 0;
        got_addr = 1'b0;
        first_addr = 32'h0;
        n = 0;
        cycle();
        while (!if_valid && n < 30) begin
            if (flush) extra++;
            if (imem_req && !got_addr) begin
                got_addr = 1'b1;
                first_addr = imem_addr;
            end
            cycle();
            n++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL redir_flush_once extra=%0d want 0", extra);
        end
        checks++;
        if (first_addr !== 32'h200) begin
            errors++;
            $display("FAIL redir_addr got %h want 200", first_addr);
        end
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== instr_of(32'h200)) begin
            errors++;
            $display("FAIL redir_if v=%b pc=%h want 1 200", if_valid, if_pc);
        end
    endtask

    task automatic test_not_taken();
        logic [31:0] exp;
        do_reset();
        rnd_rdy = 1'b1;
        rnd_lat = 1'b1;
        exp = 32'h0;
        for (int i = 0; i < 60; i++) begin
            checks++;
            if (flush !== 1'b0 || misalign !== 1'b0) begin
                errors++;
                $display("FAIL nt_flush c%0d flush=%b mis=%b", i, flush, misalign);
            end
            if (if_valid) begin
                checks++;
                if (if_pc !== exp || if_instr !== instr_of(exp)) begin
                    errors++;
                    $display("FAIL nt_if pc=%h want %h", if_pc, exp);
                end
                exp = exp + 32'd4;
            end
            redirect_valid  = 1'($urandom_range(0, 1));
            redirect_taken  = 1'b0;
            redirect_target = $urandom;
            cycle();
        end
        redirect_valid = 1'b0;
        checks++;
        if (exp == 32'h0) begin
            errors++;
            $display("FAIL nt_progress delivered=0 want >0");
        end
    endtask

    task automatic test_misalign();
        do_reset();
        lat = 1;
        cycle();
        cycle();
        redirect_valid  = 1'b1;
        redirect_taken  = 1'b1;
        redirect_target = 32'h202;
        cycle();
        redirect_valid = 1'b0;
        checks++;
        if (misalign !== 1'b1 || flush !== 1'b1) begin
            errors++;
            $display("FAIL mis_pulse mis=%b flush=%b want 1 1", misalign, flush);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL mis_trap req=%b addr=%h want 1 100", imem_req, imem_addr);
        end
        cycle();
        checks++;
        if (misalign !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL mis_once mis=%b flush=%b want 0 0", misalign, flush);
        end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        lat = 1;
        redirect_valid  = 1'b1;
        redirect_taken  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        n = 0;
        while (!if_valid && n < 20) begin
            cycle();
            n++;
        end
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_if v=%b pc=%h want 1 fffffffc", if_valid, if_pc);
        end
        cycle();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
        n = 0;
        while (!(imem_req && imem_addr == 32'h4) && n < 20) begin
            cycle();
            n++;
        end
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait req=%b v=%b want 0 0", imem_req, if_valid);
        end
        cycle();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_wait_addr req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        logic [31:0] tgt;
        logic [31:0] last_addr;
        bit          last_req;
        bit          prev_redir;
        bit          prev_mis;
        bit          prev_pend;
        bit          rd;
        int          delivered;
        do_reset();
        rnd_rdy = 1'b1;
        rnd_lat = 1'b1;
        exp = 32'h0;
        prev_redir = 1'b0;
        prev_mis = 1'b0;
        prev_pend = 1'b0;
        last_addr = 32'h0;
        delivered = 0;
        for (int i = 0; i < 500; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_taken = 1'($urandom_range(0, 1));
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            redirect_target = tgt;
            rd = redirect_valid && redirect_taken;
            checks++;
            if (flush !== prev_redir || misalign !== prev_mis) begin
                errors++;
                $display("FAIL rnd_pulse c%0d flush=%b mis=%b want %b %b",
                         i, flush, misalign, prev_redir, prev_mis);
            end
            if (imem_req) begin
                checks++;
                if (imem_addr[1:0] !== 2'b00) begin
                    errors++;
                    $display("FAIL rnd_align addr=%h", imem_addr);
                end
            end
            if (prev_pend) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== last_addr) begin
                    errors++;
                    $display("FAIL rnd_stable req=%b addr=%h want 1 %h",
                             imem_req, imem_addr, last_addr);
                end
            end
            if (if_valid && !stall && !rd) begin
                checks++;
                if (if_pc !== exp || if_instr !== instr_of(exp)) begin
                    errors++;
                    $display("FAIL rnd_if c%0d pc=%h instr=%h want %h %h",
                             i, if_pc, if_instr, exp, instr_of(exp));
                end
                exp = exp + 32'd4;
                delivered++;
            end
            if (rd) exp = (tgt[1:0] != 2'b00) ? 32'h100 : tgt;
            prev_redir = rd;
            prev_mis = rd && (tgt[1:0] != 2'b00);
            last_req = imem_req;
            last_addr = imem_addr;
            cycle();
            prev_pend = last_req && !imem_ready;
        end
        redirect_valid = 1'b0;
        stall = 1'b0;
        checks++;
        if (m_dup != 0) begin
            errors++;
            $display("FAIL rnd_outstanding dup=%0d want 0", m_dup);
        end
        checks++;
        if (delivered < 10) begin
            errors++;
            $display("FAIL rnd_progress delivered=%0d want >=10", delivered);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_not_taken();
        test_misalign();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
